// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
// Imported by the interface, the bit counter and the top level.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Counter width for a WIDTH-bit frame; never narrower than one bit.
    function automatic int cnt_w(input int width);
        int c;
        c = $clog2(width);
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle for piso_serializer.
// master = word source / link consumer side, slave = the serializer.
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = piso_pkg::cnt_w(WIDTH);

    logic [WIDTH-1:0] din;
    logic             load_valid;
    logic             load_ready;
    logic             shift_en;
    logic             sout;
    logic             sout_valid;
    logic             last;
    logic             busy;
    logic [CNT_W-1:0] bit_cnt;

    modport master (
        output din,
        output load_valid,
        output shift_en,
        input  load_ready,
        input  sout,
        input  sout_valid,
        input  last,
        input  busy,
        input  bit_cnt
    );

    modport slave (
        input  din,
        input  load_valid,
        input  shift_en,
        output load_ready,
        output sout,
        output sout_valid,
        output last,
        output busy,
        output bit_cnt
    );

endinterface

// File: rtl/piso_serializer_bit_counter.sv
// Frame bit-index counter: clear has priority over enable, tc flags the
// final bit index (WIDTH-1).
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (en) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt = cnt_reg;
    assign tc  = (cnt_reg == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parametrised PISO shift register with valid/ready load, baud-tick shift
// enable, selectable bit order and a last-bit framing flag.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    piso_serializer_if.slave    bus
);

    localparam int CNT_W = cnt_w(WIDTH);

    localparam logic [0:0] ST_IDLE  = IDLE;
    localparam logic [0:0] ST_SHIFT = SHIFT;

    logic [0:0]       state_reg;
    logic [0:0]       state_next;
    logic [WIDTH-1:0] shreg_reg;
    logic [WIDTH-1:0] shreg_next;
    logic [WIDTH-1:0] shifted;
    logic [CNT_W-1:0] cnt;
    logic             tc;
    logic             shifting;
    logic             last_bit;
    logic             advance;
    logic             finish;
    logic             ready;
    logic             accept;
    logic             out_bit;

    assign shifting = (state_reg == ST_SHIFT);
    assign last_bit = shifting & tc;
    assign advance  = shifting & bus.shift_en & ~last_bit;
    assign finish   = last_bit & bus.shift_en;

    // Ready on the final shifting bit lets a new word follow with no gap.
    assign ready    = ~shifting | finish;
    assign accept   = bus.load_valid & ready;

    // Shift toward the output end, filling the vacated position with 0.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (MSB_FIRST) begin : g_left
                if (gi == 0) begin : g_fill
                    assign shifted[gi] = 1'b0;
                end else begin : g_move
                    assign shifted[gi] = shreg_reg[gi-1];
                end
            end else begin : g_right
                if (gi == WIDTH - 1) begin : g_fill
                    assign shifted[gi] = 1'b0;
                end else begin : g_move
                    assign shifted[gi] = shreg_reg[gi+1];
                end
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        shreg_next = shreg_reg;
        if (accept) begin
            state_next = ST_SHIFT;
            shreg_next = bus.din;
        end else if (finish) begin
            state_next = ST_IDLE;
            shreg_next = '0;
        end else if (advance) begin
            shreg_next = shifted;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            shreg_reg <= '0;
        end else begin
            state_reg <= state_next;
            shreg_reg <= shreg_next;
        end
    end

    piso_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept | finish),
        .en    (advance),
        .cnt   (cnt),
        .tc    (tc)
    );

    assign out_bit        = MSB_FIRST ? shreg_reg[WIDTH-1] : shreg_reg[0];
    assign bus.sout       = shifting ? out_bit : IDLE_LEVEL;
    assign bus.sout_valid = shifting;
    assign bus.busy       = shifting;
    assign bus.last       = last_bit;
    assign bus.load_ready = ready;
    assign bus.bit_cnt    = cnt;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: three 4-bit serializers (MSB-first/idle 0, LSB-first,
// idle-high) driven through their interfaces, outputs sampled 1ns after clk.
module tb_piso_serializer;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    piso_serializer_if #(.WIDTH(4)) ifa ();
    piso_serializer_if #(.WIDTH(4)) ifb ();
    piso_serializer_if #(.WIDTH(4)) ifc ();

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
        .clk (clk), .rst_n (rst_n), .bus (ifa)
    );
    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_b (
        .clk (clk), .rst_n (rst_n), .bus (ifb)
    );
    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_c (
        .clk (clk), .rst_n (rst_n), .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifa.din = '0; ifa.load_valid = 1'b0; ifa.shift_en = 1'b1;
        ifb.din = '0; ifb.load_valid = 1'b0; ifb.shift_en = 1'b1;
        ifc.din = '0; ifc.load_valid = 1'b0; ifc.shift_en = 1'b1;
        #3;
        vectors++;
        if (ifa.sout !== 1'b0 || ifa.sout_valid !== 1'b0 || ifa.last !== 1'b0 ||
            ifa.busy !== 1'b0 || ifa.load_ready !== 1'b1 || ifa.bit_cnt !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_a: sout=%b valid=%b last=%b busy=%b ready=%b cnt=%0d expected 0 0 0 0 1 0",
                     ifa.sout, ifa.sout_valid, ifa.last, ifa.busy, ifa.load_ready, ifa.bit_cnt);
        end
        vectors++;
        if (ifc.sout !== 1'b1 || ifc.sout_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_c_idle: sout=%b valid=%b expected 1 0", ifc.sout, ifc.sout_valid);
        end
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        $display("reset: released, idle outputs checked");
    endtask

    task automatic test_single();
        logic [0:3] e_sout = 4'b1011;
        logic [0:3] e_last = 4'b0001;
        ifa.din = 4'b1011; ifa.load_valid = 1'b1;
        tick();
        ifa.load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (ifa.sout !== e_sout[i] || ifa.sout_valid !== 1'b1 || ifa.busy !== 1'b1 ||
                ifa.last !== e_last[i] || ifa.bit_cnt !== 2'(i) || ifa.load_ready !== e_last[i]) begin
                miscompares++;
                $display("FAIL single bit %0d: sout=%b valid=%b last=%b cnt=%0d ready=%b expected %b 1 %b %0d %b",
                         i, ifa.sout, ifa.sout_valid, ifa.last, ifa.bit_cnt, ifa.load_ready,
                         e_sout[i], e_last[i], i, e_last[i]);
            end
            tick();
        end
        vectors++;
        if (ifa.sout !== 1'b0 || ifa.sout_valid !== 1'b0 || ifa.load_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL single_end: sout=%b valid=%b ready=%b expected 0 0 1",
                     ifa.sout, ifa.sout_valid, ifa.load_ready);
        end
        $display("single: frame 1011 MSB-first");
    endtask

    task automatic test_back_to_back();
        logic [0:7] e_sout = 8'b1011_0111;
        ifa.din = 4'b1011; ifa.load_valid = 1'b1;
        tick();
        ifa.din = 4'b0111;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (ifa.sout !== e_sout[i] || ifa.sout_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b bit %0d: sout=%b valid=%b expected %b 1",
                         i, ifa.sout, ifa.sout_valid, e_sout[i]);
            end
            if (i == 3) begin
                vectors++;
                if (ifa.load_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_ready_on_last: ready=%b expected 1", ifa.load_ready);
                end
            end
            if (i == 4) ifa.load_valid = 1'b0;
            tick();
        end
        vectors++;
        if (ifa.sout_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_end: valid=%b expected 0", ifa.sout_valid);
        end
        $display("back_to_back: 1011 then 0111 contiguous");
    endtask

    task automatic test_stall();
        logic [1:8] e_sout = 8'b1100_1111;
        logic [1:8] e_last = 8'b0000_0011;
        logic [1:0] e_cnt [1:8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
        ifa.din = 4'b1011; ifa.load_valid = 1'b1; ifa.shift_en = 1'b1;
        tick();
        ifa.load_valid = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            ifa.shift_en = (j % 2 == 0);
            vectors++;
            if (ifa.sout !== e_sout[j] || ifa.bit_cnt !== e_cnt[j] ||
                ifa.last !== e_last[j] || ifa.sout_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL stall cycle %0d: sout=%b cnt=%0d last=%b valid=%b expected %b %0d %b 1",
                         j, ifa.sout, ifa.bit_cnt, ifa.last, ifa.sout_valid, e_sout[j], e_cnt[j], e_last[j]);
            end
            tick();
        end
        ifa.shift_en = 1'b1;
        vectors++;
        if (ifa.sout_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_end: valid=%b expected 0 after 8 cycles", ifa.sout_valid);
        end
        $display("stall: shift_en toggling, 8-cycle frame");
    endtask

    task automatic test_order_idle();
        logic [0:3] e_b = 4'b1101;
        logic [0:3] e_c = 4'b1011;
        ifb.din = 4'b1011; ifb.load_valid = 1'b1;
        ifc.din = 4'b1011; ifc.load_valid = 1'b1;
        tick();
        ifb.load_valid = 1'b0;
        ifc.load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (ifb.sout !== e_b[i] || ifc.sout !== e_c[i]) begin
                miscompares++;
                $display("FAIL order bit %0d: lsb_first sout=%b expected %b, idle_high sout=%b expected %b",
                         i, ifb.sout, e_b[i], ifc.sout, e_c[i]);
            end
            tick();
        end
        vectors++;
        if (ifc.sout !== 1'b1 || ifc.sout_valid !== 1'b0 || ifb.sout !== 1'b0) begin
            miscompares++;
            $display("FAIL order_idle: idle_high sout=%b valid=%b expected 1 0, lsb_first sout=%b expected 0",
                     ifc.sout, ifc.sout_valid, ifb.sout);
        end
        $display("order_idle: LSB-first and idle-high variants");
    endtask

    task automatic test_busy_reject();
        logic [0:3] e_sout = 4'b1011;
        ifa.din = 4'b1011; ifa.load_valid = 1'b1;
        tick();
        ifa.load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                ifa.din = 4'b1111; ifa.load_valid = 1'b1;
            end
            if (i == 3) ifa.load_valid = 1'b0;
            vectors++;
            if (ifa.sout !== e_sout[i]) begin
                miscompares++;
                $display("FAIL reject bit %0d: sout=%b expected %b", i, ifa.sout, e_sout[i]);
            end
            if (i == 1 || i == 2) begin
                vectors++;
                if (ifa.load_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL reject_ready bit %0d: ready=%b expected 0", i, ifa.load_ready);
                end
            end
            tick();
        end
        vectors++;
        if (ifa.sout_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reject_end: valid=%b expected 0 (word accepted while busy)", ifa.sout_valid);
        end
        $display("busy_reject: load during frame ignored");
    endtask

    task automatic test_reset_midframe();
        logic [0:3] e_sout = 4'b0110;
        ifa.din = 4'b1111; ifa.load_valid = 1'b1;
        tick();
        ifa.load_valid = 1'b0;
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (ifa.sout_valid !== 1'b0 || ifa.sout !== 1'b0 || ifa.last !== 1'b0 ||
            ifa.bit_cnt !== 2'd0 || ifa.load_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset: valid=%b sout=%b last=%b cnt=%0d ready=%b expected 0 0 0 0 1",
                     ifa.sout_valid, ifa.sout, ifa.last, ifa.bit_cnt, ifa.load_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ifa.din = 4'b0110; ifa.load_valid = 1'b1;
        tick();
        ifa.load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (ifa.sout !== e_sout[i] || ifa.sout_valid !== 1'b1 || ifa.bit_cnt !== 2'(i)) begin
                miscompares++;
                $display("FAIL post_reset bit %0d: sout=%b valid=%b cnt=%0d expected %b 1 %0d",
                         i, ifa.sout, ifa.sout_valid, ifa.bit_cnt, e_sout[i], i);
            end
            tick();
        end
        vectors++;
        if (ifa.sout_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_end: valid=%b expected 0", ifa.sout_valid);
        end
        $display("reset_midframe: frame dropped, clean 0110 frame after release");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_order_idle();
        test_busy_reject();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
